play_progress: RTL and testbench

- Downstream monitor of the mp3 streaming stage. Consumes the current song index, the stream read address, the song length and the suspend flag.
- Produces three things: an elapsed play time in BCD mm:ss, a progress-bar width for the 128-pixel OLED, and a one-cycle end-of-song pulse.
- Feeds the oled and DigitShow stages. It has no effect on mp3 data flow.

---
 rtl/play_progress_pkg.sv | 21 ++
 rtl/progress_divider.sv | 88 ++++++++
 rtl/play_progress.sv | 164 ++++++++++++++++
 tb/tb_play_progress.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/play_progress_pkg.sv
// Shared types and constants for the play-progress monitor: divider state
// encoding, numerator width and the BCD time saturation point (99:59).
package play_progress_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int N_W    = 40;
  localparam int ADDR_W = 32;
  localparam int BCD_W  = 4;

  localparam logic [BCD_W-1:0] SAT_MIN_HI = 4'd9;
  localparam logic [BCD_W-1:0] SAT_MIN_LO = 4'd9;
  localparam logic [BCD_W-1:0] SAT_SEC_HI = 4'd5;
  localparam logic [BCD_W-1:0] SAT_SEC_LO = 4'd9;

endpackage

// File: rtl/progress_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, with the result
// clamped to the full-bar value.
module progress_divider
  import play_progress_pkg::*;
#(
  parameter int BAR_MAX = 128,
  parameter int BAR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_W-1:0]    num,
  input  logic [ADDR_W-1:0] den,
  output logic              done,
  output logic [BAR_W-1:0]  quotient,
  output div_state_t        state
);

  // Handshake: start is sampled only while state == IDLE; done is high for
  // exactly the one DONE cycle, when quotient is valid; abort forces IDLE.
  localparam logic [5:0] LAST_BIT = 6'(N_W - 1);

  div_state_t        state_next;
  logic [N_W-1:0]    num_r;
  logic [N_W-1:0]    quo;
  logic [ADDR_W-1:0] den_r;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] rem_diff;
  logic [ADDR_W-1:0] rem_next;
  logic [ADDR_W:0]   rem_sh;
  logic              fits;
  logic [5:0]        cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (den == '0) ? DONE : DIV;
      DIV:     if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // The remainder stays below den, so the low 32 bits of the difference are exact.
  assign rem_sh   = {rem, num_r[N_W-1]};
  assign fits     = rem_sh >= {1'b0, den_r};
  assign rem_diff = rem_sh[ADDR_W-1:0] - den_r;
  assign rem_next = fits ? rem_diff : rem_sh[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r <= '0;
      den_r <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          num_r <= num;
          den_r <= den;
          rem   <= '0;
          quo   <= '0;
          cnt   <= '0;
        end
        DIV: begin
          num_r <= {num_r[N_W-2:0], 1'b0};
          rem   <= rem_next;
          quo   <= {quo[N_W-2:0], fits};
          cnt   <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign done     = (state == DONE);
  assign quotient = (quo > N_W'(BAR_MAX)) ? BAR_W'(BAR_MAX) : quo[BAR_W-1:0];

endmodule

// File: rtl/play_progress.sv
// Play-progress monitor: filtered address capture, 1 s prescaler with BCD
// mm:ss, end-of-song detection and the progress-bar divider launch.
module play_progress
  import play_progress_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int BAR_MAX = 128,
  parameter int BAR_W   = 8
) (
  input  logic             CLK_100MHz,
  input  logic             RESET,
  input  logic [31:0]      song_idx,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      music_size,
  input  logic             is_suspending,
  output logic [7:0]       elapsed_min_bcd,
  output logic [7:0]       elapsed_sec_bcd,
  output logic             sec_tick,
  output logic [BAR_W-1:0] progress,
  output logic             progress_valid,
  output logic             song_end
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);

  logic [31:0] a1, a2, addr_s, song_q, song_prev, size_q;
  logic [31:0] snap_addr, snap_size;
  logic        song_change, addr_stable, addr_dec;
  logic [PW-1:0] presc;
  logic        wrap, at_max;
  logic [BCD_W-1:0] sec_lo, sec_hi, min_lo, min_hi;
  logic        armed, end_flag, end_cond, end_cond_q, end_fire;
  logic        launch, div_done;
  logic [N_W-1:0]   div_num;
  logic [BAR_W-1:0] div_q;
  div_state_t  div_state;

  assign song_change = (song_q != song_prev);
  assign addr_stable = (a1 == a2);
  assign addr_dec    = addr_stable && (a2 < addr_s);

  // mem_addr comes from another clock domain; accept it only once two samples agree.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      a1 <= '0; a2 <= '0; addr_s <= '0;
      song_q <= '0; song_prev <= '0; size_q <= '0;
    end else begin
      a1        <= mem_addr;
      a2        <= a1;
      if (addr_stable) addr_s <= a2;
      song_q    <= song_idx;
      song_prev <= song_q;
      size_q    <= music_size;
    end
  end

  // A wrap is honoured even if suspend arrives in that same cycle.
  assign wrap   = (presc == PRESC_TOP) && !end_flag;
  assign at_max = (min_hi == SAT_MIN_HI) && (min_lo == SAT_MIN_LO) &&
                  (sec_hi == SAT_SEC_HI) && (sec_lo == SAT_SEC_LO);

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (song_change || wrap) begin
      presc <= '0;
    end else if (!is_suspending && !end_flag) begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      sec_lo <= '0; sec_hi <= '0; min_lo <= '0; min_hi <= '0;
      sec_tick <= 1'b0;
    end else if (song_change) begin
      sec_lo <= '0; sec_hi <= '0; min_lo <= '0; min_hi <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= wrap;
      if (wrap && !at_max) begin
        if (sec_lo != SAT_SEC_LO) begin
          sec_lo <= sec_lo + 1'b1;
        end else begin
          sec_lo <= '0;
          if (sec_hi != SAT_SEC_HI) begin
            sec_hi <= sec_hi + 1'b1;
          end else begin
            sec_hi <= '0;
            if (min_lo != SAT_MIN_LO) begin
              min_lo <= min_lo + 1'b1;
            end else begin
              min_lo <= '0;
              min_hi <= min_hi + 1'b1;
            end
          end
        end
      end
    end
  end

  assign elapsed_min_bcd = {min_hi, min_lo};
  assign elapsed_sec_bcd = {sec_hi, sec_lo};

  assign end_cond = (size_q != '0) && (addr_s >= size_q - 32'd1);
  assign end_fire = armed && end_cond && !end_cond_q;

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      armed <= 1'b0; end_flag <= 1'b0; end_cond_q <= 1'b0; song_end <= 1'b0;
    end else begin
      end_cond_q <= end_cond;
      song_end   <= end_fire && !song_change;
      if (song_change || addr_dec) begin
        armed    <= 1'b1;
        end_flag <= 1'b0;
      end else if (end_fire) begin
        armed    <= 1'b0;
        end_flag <= 1'b1;
      end
    end
  end

  // The snapshot feeds the divider, so LOAD divides exactly what was compared.
  assign launch  = (div_state == IDLE) && !song_change &&
                   ((addr_s != snap_addr) || (size_q != snap_size));
  assign div_num = N_W'(snap_addr) * N_W'(BAR_MAX);

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      snap_addr <= '0; snap_size <= '0;
      progress  <= '0; progress_valid <= 1'b0;
    end else begin
      if (launch) begin
        snap_addr <= addr_s;
        snap_size <= size_q;
      end
      if (song_change) begin
        progress       <= '0;
        progress_valid <= 1'b0;
      end else if (div_done) begin
        progress       <= div_q;
        progress_valid <= 1'b1;
      end
    end
  end

  progress_divider #(
    .BAR_MAX (BAR_MAX),
    .BAR_W   (BAR_W)
  ) u_div (
    .clk      (CLK_100MHz),
    .rst      (RESET),
    .start    (launch),
    .abort    (song_change),
    .num      (div_num),
    .den      (snap_size),
    .done     (div_done),
    .quotient (div_q),
    .state    (div_state)
  );

endmodule

// File: tb/tb_play_progress.sv
// Bench for play_progress: directed scenario with a per-cycle time/pulse model
// and hand-computed checkpoints for the progress bar and end-of-song handling.
module tb_play_progress;

  localparam int CLK_HZ  = 100;
  localparam int BAR_MAX = 128;
  localparam int BAR_W   = 8;

  logic             clk = 1'b0;
  logic             RESET;
  logic [31:0]      song_idx, mem_addr, music_size;
  logic             is_suspending;
  logic [7:0]       elapsed_min_bcd, elapsed_sec_bcd;
  logic             sec_tick, progress_valid, song_end;
  logic [BAR_W-1:0] progress;

  int checks = 0, failures = 0, tick_cnt = 0, end_cnt = 0, t0 = 0;

  // Model state: elapsed whole seconds, second phase, capture history, end detect.
  logic [31:0] md_m1, md_m2, md_addr, md_s1, md_s2, md_size;
  int          md_secs, md_phase;
  logic        md_armed, md_ended, md_endc_q, md_tick, md_end;

  always #5 clk = ~clk;

  play_progress #(.CLK_HZ(CLK_HZ), .BAR_MAX(BAR_MAX), .BAR_W(BAR_W)) dut (
    .CLK_100MHz      (clk),
    .RESET           (RESET),
    .song_idx        (song_idx),
    .mem_addr        (mem_addr),
    .music_size      (music_size),
    .is_suspending   (is_suspending),
    .elapsed_min_bcd (elapsed_min_bcd),
    .elapsed_sec_bcd (elapsed_sec_bcd),
    .sec_tick        (sec_tick),
    .progress        (progress),
    .progress_valid  (progress_valid),
    .song_end        (song_end)
  );

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Behavioural model, advanced on each clock edge from the driven inputs.
  initial begin
    logic song_chg, endc, upd, dec, fire;
    forever begin
      @(posedge clk or posedge RESET);
      if (RESET) begin
        md_m1 = '0; md_m2 = '0; md_addr = '0; md_s1 = '0; md_s2 = '0; md_size = '0;
        md_secs = 0; md_phase = 0;
        md_armed = 1'b0; md_ended = 1'b0; md_endc_q = 1'b0; md_tick = 1'b0; md_end = 1'b0;
      end else begin
        song_chg = (md_s1 != md_s2);
        endc     = (md_size != 32'd0) && (md_addr >= md_size - 32'd1);
        upd      = (md_m1 == md_m2);
        dec      = upd && (md_m2 < md_addr);
        fire     = md_armed && endc && !md_endc_q;
        md_tick  = 1'b0;
        if (song_chg) begin
          md_secs  = 0;
          md_phase = 0;
        end else if (!md_ended) begin
          if (md_phase == CLK_HZ - 1) begin
            md_phase = 0;
            md_secs  = (md_secs == 99 * 60 + 59) ? md_secs : md_secs + 1;
            md_tick  = 1'b1;
          end else if (!is_suspending) begin
            md_phase = md_phase + 1;
          end
        end
        md_end = fire && !song_chg;
        if (song_chg || dec) begin
          md_armed = 1'b1;
          md_ended = 1'b0;
        end else if (fire) begin
          md_armed = 1'b0;
          md_ended = 1'b1;
        end
        md_endc_q = endc;
        if (upd) md_addr = md_m2;
        md_m2 = md_m1;  md_m1 = mem_addr;
        md_s2 = md_s1;  md_s1 = song_idx;
        md_size = music_size;
      end
    end
  end

  // Per-cycle compare against the model, plus pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (!RESET) begin
        check("elapsed_time", 32'({elapsed_min_bcd, elapsed_sec_bcd}),
              32'({to_bcd(md_secs / 60), to_bcd(md_secs % 60)}));
        check("sec_tick", 32'(sec_tick), 32'(md_tick));
        check("song_end", 32'(song_end), 32'(md_end));
        if (sec_tick) tick_cnt++;
        if (song_end) end_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; song_idx = '0; mem_addr = '0; music_size = '0; is_suspending = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_min", 32'(elapsed_min_bcd), 32'h00);
    check("reset_sec", 32'(elapsed_sec_bcd), 32'h00);
    check("reset_progress", 32'(progress), 32'd0);
    check("reset_valid", 32'(progress_valid), 32'd0);
    check("reset_pulses", 32'({sec_tick, song_end}), 32'd0);
    RESET = 1'b0;
    tick_cnt = 0;
    end_cnt  = 0;

    // 6100 playing cycles at 100 cycles per second
    wait_edges(6100);
    check("tick_count_61", 32'(tick_cnt), 32'd61);
    check("time_min_01", 32'(elapsed_min_bcd), 32'h01);
    check("time_sec_01", 32'(elapsed_sec_bcd), 32'h01);

    // Pause 37 cycles into a second; resuming needs 63 more cycles to tick
    wait_edges(37);
    is_suspending = 1'b1;
    t0 = tick_cnt;
    wait_edges(500);
    check("suspend_no_tick", 32'(tick_cnt - t0), 32'd0);
    check("suspend_sec_held", 32'(elapsed_sec_bcd), 32'h01);
    is_suspending = 1'b0;
    wait_edges(62);
    check("resume_before_wrap", 32'(elapsed_sec_bcd), 32'h01);
    wait_edges(1);
    check("resume_wrap_sec", 32'(elapsed_sec_bcd), 32'h02);
    check("resume_tick_count", 32'(tick_cnt - t0), 32'd1);

    // Progress: 6582 * 128 / 13164 = 64
    music_size = 32'd13164;
    wait_edges(60);
    check("size_only_progress", 32'(progress), 32'd0);
    check("size_only_valid", 32'(progress_valid), 32'd1);
    mem_addr = 32'd6582;
    wait_edges(40);
    check("progress_not_yet", 32'(progress), 32'd0);
    wait_edges(8);
    check("progress_half", 32'(progress), 32'd64);
    check("progress_half_valid", 32'(progress_valid), 32'd1);

    // Clamp: 20000 * 128 / 13164 = 194 -> 128; not armed, so no song_end
    mem_addr = 32'd20000;
    wait_edges(48);
    check("progress_clamp", 32'(progress), 32'd128);
    check("clamp_no_end", 32'(end_cnt), 32'd0);

    // Zero size
    music_size = 32'd0;
    wait_edges(48);
    check("zero_size_progress", 32'(progress), 32'd0);
    check("zero_size_no_end", 32'(end_cnt), 32'd0);

    // Address drops (re-arms), then ramp to the last word
    mem_addr = 32'd100;
    wait_edges(10);
    music_size = 32'd13164;
    wait_edges(60);
    for (int a = 1100; a <= 12100; a += 1000) begin
      mem_addr = 32'(a);
      wait_edges(5);
    end
    mem_addr = 32'd13163;
    wait_edges(10);
    check("end_one_pulse", 32'(end_cnt), 32'd1);
    t0 = tick_cnt;
    wait_edges(300);
    check("end_time_frozen", 32'(tick_cnt - t0), 32'd0);
    check("end_still_one", 32'(end_cnt), 32'd1);

    // Song change clears time and progress
    song_idx = 32'd1;
    wait_edges(2);
    check("change_min", 32'(elapsed_min_bcd), 32'h00);
    check("change_sec", 32'(elapsed_sec_bcd), 32'h00);
    check("change_valid", 32'(progress_valid), 32'd0);
    check("change_progress", 32'(progress), 32'd0);
    check("change_no_end", 32'(end_cnt), 32'd1);

    // Re-armed: end condition falls then rises again -> second pulse
    music_size = 32'd20000;
    wait_edges(60);
    music_size = 32'd13164;
    wait_edges(60);
    check("rearm_second_end", 32'(end_cnt), 32'd2);
    check("rearm_progress_127", 32'(progress), 32'd127);
    check("rearm_valid", 32'(progress_valid), 32'd1);

    // Song change while the divider is mid-run
    mem_addr = 32'd3000;
    wait_edges(10);
    song_idx = 32'd2;
    wait_edges(80);
    check("abort_progress", 32'(progress), 32'd0);
    check("abort_valid", 32'(progress_valid), 32'd0);
    wait_edges(250);

    // Asynchronous reset, observed before the next rising edge
    RESET = 1'b1;
    #1;
    check("async_min", 32'(elapsed_min_bcd), 32'h00);
    check("async_sec", 32'(elapsed_sec_bcd), 32'h00);
    check("async_progress", 32'(progress), 32'd0);
    check("async_valid", 32'(progress_valid), 32'd0);
    check("async_pulses", 32'({sec_tick, song_end}), 32'd0);
    wait_edges(2);
    RESET = 1'b0;
    wait_edges(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
